// File: rtl/mips_bus_pkg.sv
// Shared definitions for the CPU-to-Avalon data bus bridge: FSM states,
// address alignment mask and timeout defaults.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StDone
    } bus_state_e;

    localparam logic [31:0] WordAlignMask  = 32'hFFFF_FFFC;
    localparam int unsigned TimeoutDefault = 255;
    localparam int unsigned TimeoutWidth   = 16;

endpackage

// File: rtl/Bus_Timeout_Counter.sv
// Saturating wait-cycle counter; expired flags the last permitted wait cycle.
module Bus_Timeout_Counter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    // count_q holds completed wait cycles, so the current one is the last at Limit.
    localparam logic [TimeoutWidth-1:0] Limit = TimeoutWidth'(TIMEOUT_CYCLES - 1);

    logic [TimeoutWidth-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count && (count_q != '1)) begin
            count_q <= count_q + TimeoutWidth'(1);
        end
    end

    assign expired = count && (count_q >= Limit);

endmodule

// File: rtl/data_bus_bridge.sv
// Bridges the CPU memory stage to an Avalon-MM master: one transfer at a time,
// stalling the pipeline until the slave completes, times out or the access is rejected.
module data_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic [31:0] cpu_readdata,
    output logic        cpu_stall,
    output logic        bus_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    bus_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        in_wait;
    logic        expired;
    logic        misaligned;

    assign in_wait    = (state_q == StReadWait) || (state_q == StWriteWait);
    assign misaligned = (cpu_address & ~WordAlignMask) != '0;

    Bus_Timeout_Counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_wait),
        .count  (in_wait),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        err_d     = err_q;
        cpu_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_read || cpu_write) begin
                    cpu_stall = 1'b1;
                    addr_d    = cpu_address;
                    wdata_d   = cpu_writedata;
                    be_d      = cpu_byteenable;
                    if (misaligned) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (cpu_write) begin
                        state_d = StWriteWait;
                        // A simultaneous read is dropped; flag it.
                        if (cpu_read) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = StReadWait;
                    end
                end
            end
            StReadWait, StWriteWait: begin
                cpu_stall = 1'b1;
                // Slave completion wins over a timeout in the same cycle.
                if (!avm_waitrequest) begin
                    state_d = StDone;
                    if (state_q == StReadWait) begin
                        rdata_d = avm_readdata;
                    end
                end else if (expired) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign avm_read       = (state_q == StReadWait);
    assign avm_write      = (state_q == StWriteWait);
    assign avm_address    = addr_q & WordAlignMask;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign cpu_readdata   = rdata_q;
    assign bus_error      = err_q;

endmodule
